// File: rtl/kudu_dv_pkg.sv
// kudu_dv_pkg: shared types and constants for the kudu DV OBI infrastructure.
//   arb_id_t     - requester ID carried through the arbiter's in-order FIFO
//   ARB_PRIO_*   - arbitration policy selectors for mem_obi_arb.PRIO_MODE
//   arb_state_t  - arbiter FSM encoding, exported for debug/checkers
//   obi_req_t    - OBI address-phase bundle used by the request mux
package kudu_dv_pkg;

   typedef logic arb_id_t;

   localparam int ARB_PRIO_RR    = 0;
   localparam int ARB_PRIO_FIXED = 1;

   // Width of the wdata field inside obi_req_t; mem_obi_arb is built with
   // DW equal to this value.
   localparam int OBI_DW = 32;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic              is_cap;
      logic              we;
      logic [3:0]        be;
      logic [31:0]       addr;
      logic [OBI_DW-1:0] wdata;
      logic [7:0]        flag;
   } obi_req_t;

endpackage

// File: rtl/obi_arb_order_fifo.sv
// obi_arb_order_fifo: in-order FIFO of requester IDs for granted-but-not-yet-
// responded OBI transactions.
// Ports:
//   clk_i, rst_ni  - clock, synchronous active-low reset (empties the FIFO)
//   push, push_id  - enqueue push_id (ignored when full)
//   pop            - dequeue head (ignored when empty)
//   head_id        - ID at the head of the FIFO
//   full, empty    - occupancy flags
//   count          - number of stored entries (0..DEPTH)
module obi_arb_order_fifo
   import kudu_dv_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push,
   input  arb_id_t                  push_id,
   input  logic                     pop,
   output arb_id_t                  head_id,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit, so full and empty are distinguishable
   // with all DEPTH slots in use; arithmetic wraps modulo 2*DEPTH.
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   arb_id_t     mem [DEPTH];

   assign count   = wr_ptr - rd_ptr;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (wr_ptr == rd_ptr);
   assign head_id = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Storage needs no reset: entries are only read between push and pop.
   always_ff @(posedge clk_i) begin
      if (push && !full) begin
         mem[wr_ptr[AW-1:0]] <= push_id;
      end
   end

endmodule

// File: rtl/mem_obi_arb.sv
// mem_obi_arb: two-requester OBI arbiter sharing one downstream OBI data port.
// Ports:
//   clk_i, rst_ni                   - clock, synchronous active-low reset
//   p0_*/p1_* address phase (in)    - req, we, is_cap, be, addr, wdata, flag
//   p0_gnt/p1_gnt (out)             - grant to each requester
//   p0_/p1_ rvalid, err, rdata (out)- routed response; rdata is 0 unless rvalid
//   out_* address phase (out)       - muxed request toward downstream
//   out_gnt, out_rvalid, out_err, out_rdata (in) - downstream grant/response
//   outs_cnt (out)                  - outstanding transaction count
//   unexp_rsp (out)                 - sticky: response seen with nothing outstanding
//   arb_state (out)                 - current arbiter FSM state (debug)
//
// Handshake: an address phase transfers in the cycle where out_req and
// out_gnt are both high; the requester sees pN_gnt in that same cycle.
// Responses carry no ready: each out_rvalid pulse is one response, returned
// in grant order.
module mem_obi_arb
   import kudu_dv_pkg::*;
#(
   parameter int DW        = 32,
   parameter int MAX_OUTS  = 8,
   parameter int PRIO_MODE = ARB_PRIO_RR
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   // requester 0
   input  logic                        p0_req,
   input  logic                        p0_we,
   input  logic                        p0_is_cap,
   input  logic [3:0]                  p0_be,
   input  logic [31:0]                 p0_addr,
   input  logic [DW-1:0]               p0_wdata,
   input  logic [7:0]                  p0_flag,
   output logic                        p0_gnt,
   output logic                        p0_rvalid,
   output logic                        p0_err,
   output logic [DW-1:0]               p0_rdata,
   // requester 1
   input  logic                        p1_req,
   input  logic                        p1_we,
   input  logic                        p1_is_cap,
   input  logic [3:0]                  p1_be,
   input  logic [31:0]                 p1_addr,
   input  logic [DW-1:0]               p1_wdata,
   input  logic [7:0]                  p1_flag,
   output logic                        p1_gnt,
   output logic                        p1_rvalid,
   output logic                        p1_err,
   output logic [DW-1:0]               p1_rdata,
   // downstream
   output logic                        out_req,
   output logic                        out_we,
   output logic                        out_is_cap,
   output logic [3:0]                  out_be,
   output logic [31:0]                 out_addr,
   output logic [DW-1:0]               out_wdata,
   output logic [7:0]                  out_flag,
   input  logic                        out_gnt,
   input  logic                        out_rvalid,
   input  logic                        out_err,
   input  logic [DW-1:0]               out_rdata,
   // status
   output logic [$clog2(MAX_OUTS):0]   outs_cnt,
   output logic                        unexp_rsp,
   output arb_state_t                  arb_state
);

   arb_state_t state_q, state_d;
   arb_id_t    sel, sel_q, sel_d;
   arb_id_t    last_q;
   logic       sel_req;
   logic       grant;
   logic       fifo_full, fifo_empty, fifo_pop;
   arb_id_t    head_id;
   obi_req_t   req0, req1, req_sel;

   assign arb_state = state_q;

   // Requester selection: free choice in IDLE, frozen while the downstream
   // port is stalling a presented address phase.
   always_comb begin
      sel = 1'b0;
      if (state_q == ARB_HOLD) begin
         sel = sel_q;
      end else if (p0_req && p1_req) begin
         sel = (PRIO_MODE == ARB_PRIO_FIXED) ? 1'b0 : ~last_q;
      end else begin
         sel = !p0_req && p1_req;
      end
   end

   assign sel_req = sel ? p1_req : p0_req;
   // A full FIFO blocks new requests even if a pop happens this cycle.
   assign out_req = sel_req && !fifo_full;
   assign grant   = out_req && out_gnt;
   assign p0_gnt  = grant && (sel == 1'b0);
   assign p1_gnt  = grant && (sel == 1'b1);

   // Address-phase mux.
   assign req0 = '{is_cap: p0_is_cap, we: p0_we, be: p0_be, addr: p0_addr,
                   wdata: OBI_DW'(p0_wdata), flag: p0_flag};
   assign req1 = '{is_cap: p1_is_cap, we: p1_we, be: p1_be, addr: p1_addr,
                   wdata: OBI_DW'(p1_wdata), flag: p1_flag};
   assign req_sel = sel ? req1 : req0;

   assign out_is_cap = req_sel.is_cap;
   assign out_we     = req_sel.we;
   assign out_be     = req_sel.be;
   assign out_addr   = req_sel.addr;
   assign out_wdata  = DW'(req_sel.wdata);
   assign out_flag   = req_sel.flag;

   // FSM next state. A requester dropping req while held is a protocol
   // violation; we simply fall back to IDLE without granting.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (out_req && !out_gnt) begin
               state_d = ARB_HOLD;
               sel_d   = sel;
            end
         end
         ARB_HOLD: begin
            if (!sel_req || out_gnt) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ARB_IDLE;
         sel_q     <= 1'b0;
         last_q    <= 1'b1;  // requester 0 wins the first round-robin tie
         unexp_rsp <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         if (grant) begin
            last_q <= sel;
         end
         if (out_rvalid && fifo_empty) begin
            unexp_rsp <= 1'b1;
         end
      end
   end

   // Response routing. A grant pushed this cycle is not yet visible at the
   // head, so a response is never routed in its own grant cycle.
   assign fifo_pop  = out_rvalid && !fifo_empty;
   assign p0_rvalid = fifo_pop && (head_id == 1'b0);
   assign p1_rvalid = fifo_pop && (head_id == 1'b1);
   assign p0_err    = p0_rvalid && out_err;
   assign p1_err    = p1_rvalid && out_err;
   assign p0_rdata  = p0_rvalid ? out_rdata : '0;
   assign p1_rdata  = p1_rvalid ? out_rdata : '0;

   obi_arb_order_fifo #(
      .DEPTH (MAX_OUTS)
   ) u_order_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push    (grant),
      .push_id (sel),
      .pop     (fifo_pop),
      .head_id (head_id),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (outs_cnt)
   );

endmodule

// File: tb/tb_mem_obi_arb.sv
// tb_mem_obi_arb: directed bench for mem_obi_arb. Two instances share all
// inputs: dut_rr (round-robin) and dut_fx (fixed priority). The bench itself
// plays the downstream memory by driving out_gnt/out_rvalid/out_rdata.
module tb_mem_obi_arb;
   import kudu_dv_pkg::*;

   localparam int DW = 32;
   localparam int MO = 8;
   localparam int CW = $clog2(MO) + 1;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   // ---------------- shared inputs ----------------
   logic          p0_req, p0_we, p0_is_cap, p1_req, p1_we, p1_is_cap;
   logic [3:0]    p0_be, p1_be;
   logic [31:0]   p0_addr, p1_addr;
   logic [DW-1:0] p0_wdata, p1_wdata;
   logic [7:0]    p0_flag, p1_flag;
   logic          out_gnt, out_rvalid, out_err;
   logic [DW-1:0] out_rdata;

   // ---------------- round-robin DUT outputs ----------------
   logic          r_p0_gnt, r_p0_rvalid, r_p0_err, r_p1_gnt, r_p1_rvalid, r_p1_err;
   logic [DW-1:0] r_p0_rdata, r_p1_rdata, r_out_wdata;
   logic          r_out_req, r_out_we, r_out_is_cap, r_unexp;
   logic [3:0]    r_out_be;
   logic [31:0]   r_out_addr;
   logic [7:0]    r_out_flag;
   logic [CW-1:0] r_outs_cnt;
   arb_state_t    r_state;

   // ---------------- fixed-priority DUT outputs ----------------
   logic          f_p0_gnt, f_p0_rvalid, f_p0_err, f_p1_gnt, f_p1_rvalid, f_p1_err;
   logic [DW-1:0] f_p0_rdata, f_p1_rdata, f_out_wdata;
   logic          f_out_req, f_out_we, f_out_is_cap, f_unexp;
   logic [3:0]    f_out_be;
   logic [31:0]   f_out_addr;
   logic [7:0]    f_out_flag;
   logic [CW-1:0] f_outs_cnt;
   arb_state_t    f_state;

   mem_obi_arb #(.DW(DW), .MAX_OUTS(MO), .PRIO_MODE(ARB_PRIO_RR)) dut_rr (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .p0_req(p0_req), .p0_we(p0_we), .p0_is_cap(p0_is_cap), .p0_be(p0_be),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_flag(p0_flag),
      .p0_gnt(r_p0_gnt), .p0_rvalid(r_p0_rvalid), .p0_err(r_p0_err), .p0_rdata(r_p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_is_cap(p1_is_cap), .p1_be(p1_be),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_flag(p1_flag),
      .p1_gnt(r_p1_gnt), .p1_rvalid(r_p1_rvalid), .p1_err(r_p1_err), .p1_rdata(r_p1_rdata),
      .out_req(r_out_req), .out_we(r_out_we), .out_is_cap(r_out_is_cap), .out_be(r_out_be),
      .out_addr(r_out_addr), .out_wdata(r_out_wdata), .out_flag(r_out_flag),
      .out_gnt(out_gnt), .out_rvalid(out_rvalid), .out_err(out_err), .out_rdata(out_rdata),
      .outs_cnt(r_outs_cnt), .unexp_rsp(r_unexp), .arb_state(r_state)
   );

   mem_obi_arb #(.DW(DW), .MAX_OUTS(MO), .PRIO_MODE(ARB_PRIO_FIXED)) dut_fx (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .p0_req(p0_req), .p0_we(p0_we), .p0_is_cap(p0_is_cap), .p0_be(p0_be),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_flag(p0_flag),
      .p0_gnt(f_p0_gnt), .p0_rvalid(f_p0_rvalid), .p0_err(f_p0_err), .p0_rdata(f_p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_is_cap(p1_is_cap), .p1_be(p1_be),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_flag(p1_flag),
      .p1_gnt(f_p1_gnt), .p1_rvalid(f_p1_rvalid), .p1_err(f_p1_err), .p1_rdata(f_p1_rdata),
      .out_req(f_out_req), .out_we(f_out_we), .out_is_cap(f_out_is_cap), .out_be(f_out_be),
      .out_addr(f_out_addr), .out_wdata(f_out_wdata), .out_flag(f_out_flag),
      .out_gnt(out_gnt), .out_rvalid(out_rvalid), .out_err(out_err), .out_rdata(out_rdata),
      .outs_cnt(f_outs_cnt), .unexp_rsp(f_unexp), .arb_state(f_state)
   );

   // ---------------- scoreboard ----------------
   int errors = 0;
   int checks = 0;
   logic [0:0] exp_q[$];   // expected requester ID of each outstanding grant

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      p0_req = 0; p0_we = 0; p0_is_cap = 0; p0_be = 4'hF; p0_addr = 32'h10;
      p0_wdata = 32'h1111_0000; p0_flag = 8'hA0;
      p1_req = 0; p1_we = 1; p1_is_cap = 1; p1_be = 4'h3; p1_addr = 32'h20;
      p1_wdata = 32'h2222_0000; p1_flag = 8'hB1;
      out_gnt = 0; out_rvalid = 0; out_err = 0; out_rdata = '0;
   endtask

   // Resets both DUTs and the bench's downstream model (its expected queue).
   task automatic do_reset();
      rst_ni = 0;
      clear_inputs();
      exp_q.delete();
      tick();
      tick();
      rst_ni = 1;
   endtask

   // ---------------- stimulus ----------------
   logic [0:0] seq_id [3];
   logic [DW-1:0] rsp_data [3];
   int rsp_wait [3];
   int g0, g1;
   logic [0:0] hid;

   initial begin
      do_reset();

      // Reset state, no requests.
      #1;
      check("rst_outs_cnt", r_outs_cnt, 0);
      check("rst_out_req", {r_out_req, f_out_req}, 0);
      check("rst_gnt", {r_p0_gnt, r_p1_gnt, f_p0_gnt, f_p1_gnt}, 0);
      check("rst_rvalid_err", {r_p0_rvalid, r_p1_rvalid, r_p0_err, r_p1_err}, 0);
      check("rst_rdata", {r_p0_rdata, r_p1_rdata}, 0);
      check("rst_unexp", r_unexp, 0);
      check("rst_state", r_state, ARB_IDLE);
      tick();

      // Both requesting every cycle, zero-wait downstream: RR alternates,
      // fixed priority keeps granting p0. Each response arrives next cycle.
      g0 = 0; g1 = 0;
      for (int i = 0; i < 10; i++) begin
         p0_req = 1; p1_req = 1; out_gnt = 1;
         out_rvalid = (i > 0); out_rdata = 32'h100 + i;
         #1;
         check("rr_gnt", {r_p0_gnt, r_p1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
         check("rr_addr", r_out_addr, (i % 2 == 0) ? 32'h10 : 32'h20);
         check("fx_gnt", {f_p0_gnt, f_p1_gnt}, 2'b10);
         if (i > 0) begin
            hid = exp_q.pop_front();
            check("rr_rvalid", {r_p0_rvalid, r_p1_rvalid}, (hid == 0) ? 2'b10 : 2'b01);
            check("rr_rdata", (hid == 0) ? r_p0_rdata : r_p1_rdata, 32'h100 + i);
            check("fx_rvalid", {f_p0_rvalid, f_p1_rvalid}, 2'b10);
         end
         exp_q.push_back((i % 2 == 0) ? 1'b0 : 1'b1);
         g0 += r_p0_gnt; g1 += r_p1_gnt;
         tick();
      end
      check("rr_g0_count", g0, 5);
      check("rr_g1_count", g1, 5);
      check("rr_outs_steady", r_outs_cnt, 1);

      // p0 drops: starved p1 now wins in fixed mode; last responses drain.
      p0_req = 0; p1_req = 1; out_gnt = 1; out_rvalid = 1; out_rdata = 32'h200;
      #1;
      check("fx_p1_after_drop", {f_p0_gnt, f_p1_gnt}, 2'b01);
      check("fx_rsp_p0", {f_p0_rvalid, f_p1_rvalid}, 2'b10);
      check("rr_p1_gnt", r_p1_gnt, 1);
      check("rr_rsp_p1", {r_p0_rvalid, r_p1_rvalid}, 2'b01);
      tick();
      p1_req = 0; out_gnt = 0; out_rvalid = 1; out_rdata = 32'h300;
      #1;
      check("fx_rsp_last", {f_p0_rvalid, f_p1_rvalid}, 2'b01);
      check("rr_rsp_last", {r_p0_rvalid, r_p1_rvalid}, 2'b01);
      check("rr_rdata_last", {r_p0_rdata, r_p1_rdata}, {32'h0, 32'h300});
      tick();
      out_rvalid = 0;
      check("drained_cnt", {r_outs_cnt, f_outs_cnt}, 0);

      // Downstream stalls grant for 3 cycles: address held, no preemption.
      do_reset();
      p0_addr = 32'h1000; p1_addr = 32'h2000;
      for (int c = 0; c < 4; c++) begin
         p0_req = 1; p1_req = 1; out_gnt = (c == 3);
         #1;
         check("hold_addr", r_out_addr, 32'h1000);
         check("hold_wdata", r_out_wdata, 32'h1111_0000);
         check("hold_p1_gnt", r_p1_gnt, 0);
         check("hold_p0_gnt", r_p0_gnt, (c == 3));
         if (c == 1) check("hold_state", r_state, ARB_HOLD);
         tick();
      end
      p0_req = 0; out_gnt = 0;
      #1;
      check("after_hold_addr", r_out_addr, 32'h2000);
      check("after_hold_flag", r_out_flag, 8'hB1);
      tick();                          // p1 now stalled -> HOLD on p1
      p1_req = 0; p0_req = 1;          // p1 abandons its request
      #1;
      check("drop_out_req", r_out_req, 0);
      check("drop_p0_gnt", r_p0_gnt, 0);
      tick();
      out_gnt = 1;
      #1;
      check("drop_recover_gnt", r_p0_gnt, 1);
      tick();

      // Interleaved grants with variable response waits.
      do_reset();
      seq_id   = '{1'b0, 1'b1, 1'b0};
      rsp_data = '{32'hA, 32'hB, 32'hC};
      rsp_wait = '{1, 2, 5};
      for (int k = 0; k < 3; k++) begin
         p0_req = (seq_id[k] == 0); p1_req = (seq_id[k] == 1); out_gnt = 1;
         #1;
         check("il_gnt", {r_p0_gnt, r_p1_gnt}, (seq_id[k] == 0) ? 2'b10 : 2'b01);
         exp_q.push_back(seq_id[k]);
         tick();
      end
      p0_req = 0; p1_req = 0; out_gnt = 0;
      check("il_outs", r_outs_cnt, 3);
      for (int k = 0; k < 3; k++) begin
         for (int w = 0; w < rsp_wait[k]; w++) begin
            out_rvalid = 0;
            #1;
            check("il_idle_rv", {r_p0_rvalid, r_p1_rvalid}, 0);
            tick();
         end
         out_rvalid = 1; out_rdata = rsp_data[k]; out_err = (k == 1);
         #1;
         hid = exp_q.pop_front();
         check("il_rvalid", {r_p0_rvalid, r_p1_rvalid}, (hid == 0) ? 2'b10 : 2'b01);
         check("il_rdata", {r_p0_rdata, r_p1_rdata},
               (hid == 0) ? {rsp_data[k], 32'h0} : {32'h0, rsp_data[k]});
         check("il_err", {r_p0_err, r_p1_err}, (k == 1) ? 2'b01 : 2'b00);
         tick();
      end
      out_rvalid = 0; out_err = 0;
      check("il_outs_end", r_outs_cnt, 0);

      // Fill all MAX_OUTS slots with responses withheld.
      do_reset();
      p0_req = 1; out_gnt = 1;
      g0 = 0;
      for (int i = 0; i < MO + 2; i++) begin
         #1;
         g0 += r_p0_gnt;
         tick();
      end
      check("full_grants", g0, MO);
      #1;
      check("full_out_req", r_out_req, 0);
      check("full_cnt", r_outs_cnt, MO);
      tick();
      out_rvalid = 1;                  // pop frees a slot only next cycle
      #1;
      check("full_pop_out_req", r_out_req, 0);
      check("full_pop_rvalid", r_p0_rvalid, 1);
      tick();
      out_rvalid = 0;
      #1;
      check("full_reassert", {r_out_req, r_p0_gnt}, 2'b11);
      check("full_cnt_after_pop", r_outs_cnt, MO - 1);
      tick();
      check("full_cnt_refill", r_outs_cnt, MO);
      do_reset();                      // reset mid-operation drops all IDs
      #1;
      check("midrst_cnt", r_outs_cnt, 0);
      check("midrst_out_req", r_out_req, 0);
      tick();

      // Unexpected response with nothing outstanding.
      out_rvalid = 1; out_rdata = 32'hDEAD;
      #1;
      check("unexp_rvalid", {r_p0_rvalid, r_p1_rvalid}, 0);
      check("unexp_rdata", {r_p0_rdata, r_p1_rdata}, 0);
      tick();
      out_rvalid = 0;
      check("unexp_set", r_unexp, 1);
      check("unexp_cnt", r_outs_cnt, 0);
      tick();
      tick();
      check("unexp_sticky", r_unexp, 1);
      do_reset();
      #1;
      check("unexp_cleared", r_unexp, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
